// File: rtl/gray_seq_gen.sv
// Gray-code source stage: binary count stepped once per accepted transfer,
// presented as a registered Gray code behind a valid/ready handshake.
module gray_seq_gen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_out,
  output logic             gray_valid,
  input  logic             gray_ready,
  output logic             tc
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ALL1 = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q, tc_d;
  logic             xfer;

  assign xfer = (state_q == SEND) && gray_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    if (load) begin
      // A transfer in the same cycle still consumes the old code, but the
      // count takes the load value and no wrap is reported.
      cnt_d   = load_val;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) state_d = SEND;
        end
        SEND: begin
          if (xfer) begin
            cnt_d   = up_dn ? (cnt_q + ONE) : (cnt_q - ONE);
            tc_d    = up_dn ? (cnt_q == ALL1) : (cnt_q == ZERO);
            state_d = en ? SEND : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Gray encoding of the next count so gray_out tracks cnt on the same edge.
  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
    assign gray_d[gi] = cnt_d[gi] ^ cnt_d[gi+1];
  end
  assign gray_d[WIDTH-1] = cnt_d[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gray_q  <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gray_q  <= gray_d;
      tc_q    <= tc_d;
    end
  end

  assign gray_out   = gray_q;
  assign gray_valid = (state_q == SEND);
  assign tc         = tc_q;

endmodule

// File: tb/tb_gray_seq_gen.sv
// Directed bench for gray_seq_gen (WIDTH=4) with hand-computed expected codes.
module tb_gray_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] gray_out;
  logic       gray_valid;
  logic       gray_ready;
  logic       tc;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  gray_seq_gen #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .up_dn      (up_dn),
    .load       (load),
    .load_val   (load_val),
    .gray_out   (gray_out),
    .gray_valid (gray_valid),
    .gray_ready (gray_ready),
    .tc         (tc)
  );

  // Up-count Gray sequence for counts 0..15.
  logic [3:0] up_seq [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                              4'b0110, 4'b0111, 4'b0101, 4'b0100,
                              4'b1100, 4'b1101, 4'b1111, 4'b1110,
                              4'b1010, 4'b1011, 4'b1001, 4'b1000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-14s got=%0h", tag, got);
    end else begin
      $display("FAIL %-14s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic v, input logic t);
    check({tag, ".gray"},  32'(gray_out),   32'(g));
    check({tag, ".valid"}, 32'(gray_valid), 32'(v));
    check({tag, ".tc"},    32'(tc),         32'(t));
  endtask

  logic [3:0] prev;

  initial begin
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0;
    load_val = 4'b0000; gray_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_out("reset", 4'b0000, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Full up-count cycle with wrap
    en = 1'b1; gray_ready = 1'b1;
    step();
    chk_out("first", 4'b0000, 1'b1, 1'b0);
    prev = gray_out;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk_out($sformatf("up%0d", i), up_seq[i % 16], 1'b1, (i == 16));
      check($sformatf("onebit%0d", i), 32'($countones(prev ^ gray_out)), 32'd1);
      prev = gray_out;
    end

    // Backpressure at 0011
    step(); step();
    check("pre_bp", 32'(gray_out), 32'(4'b0011));
    gray_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("bp%0d", i), 4'b0011, 1'b1, 1'b0);
    end
    gray_ready = 1'b1;
    step();
    chk_out("bp_release", 4'b0010, 1'b1, 1'b0);

    // en drop while stalled: valid holds until the transfer
    gray_ready = 1'b0; en = 1'b0;
    step(); step();
    chk_out("endrop_hold", 4'b0010, 1'b1, 1'b0);
    gray_ready = 1'b1;
    step();
    chk_out("endrop_xfer", 4'b0110, 1'b0, 1'b0);
    step();
    chk_out("idle_ready", 4'b0110, 1'b0, 1'b0);

    // Down count from a fresh reset
    #2 rst_n = 1'b0;
    #1 chk_out("rst2", 4'b0000, 1'b0, 1'b0);
    up_dn = 1'b0; en = 1'b1; gray_ready = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    step();
    chk_out("dn0", 4'b0000, 1'b1, 1'b0);
    step();
    chk_out("dn_wrap", 4'b1000, 1'b1, 1'b1);
    step();
    chk_out("dn2", 4'b1001, 1'b1, 1'b0);

    // Load mid-stream (coincides with a transfer)
    up_dn = 1'b1; load = 1'b1; load_val = 4'b1010;
    step();
    chk_out("load", 4'b1111, 1'b0, 1'b0);
    load = 1'b0;
    step();
    chk_out("load_bubble", 4'b1111, 1'b1, 1'b0);
    step();
    chk_out("load_step", 4'b1110, 1'b1, 1'b0);

    // Load coinciding with a wrapping transfer: no tc
    load = 1'b1; load_val = 4'b1111;
    step();
    chk_out("load_f", 4'b1000, 1'b0, 1'b0);
    load = 1'b0;
    step();
    chk_out("at_f", 4'b1000, 1'b1, 1'b0);
    load = 1'b1; load_val = 4'b0101;
    step();
    chk_out("load_wrap", 4'b0111, 1'b0, 1'b0);
    load = 1'b0;
    step();
    chk_out("after_load", 4'b0111, 1'b1, 1'b0);

    // Async reset mid-SEND
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 4'b0000, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk_out("post_rst", 4'b0000, 1'b1, 1'b0);
    step();
    chk_out("post_rst1", 4'b0001, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
